// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline slice: ALU op codes, RV32 opcodes
// and the bundle of control bits that travels with an instruction into EX.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_PASS = 4'b1000
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // An all-zero value of this struct is a bubble.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic illegal;
    logic use_imm;
  } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ID-side decode of opcode/funct3/funct7[5] into the ALU op
// code, the EX/MEM control bits and the operand-usage flags.
module alu_ctrl_dec
  import pipe_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_op_t    alu_op_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       illegal_o,
  output logic       use_imm_o,
  output logic       uses_rs2_o
);

  always_comb begin
    alu_op_o    = ALU_ADD;
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    branch_o    = 1'b0;
    illegal_o   = 1'b0;
    use_imm_o   = 1'b0;
    uses_rs2_o  = 1'b0;

    case (opcode_i)
      OP_R: begin
        uses_rs2_o  = 1'b1;
        reg_write_o = 1'b1;
        case (funct3_i)
          3'b000:  alu_op_o = funct7_5_i ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b111:  alu_op_o = ALU_AND;
          3'b110:  alu_op_o = ALU_OR;
          default: begin
            illegal_o   = 1'b1;
            reg_write_o = 1'b0;
          end
        endcase
      end
      OP_I: begin
        use_imm_o   = 1'b1;
        reg_write_o = 1'b1;
        case (funct3_i)
          3'b000:  alu_op_o = ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b111:  alu_op_o = ALU_AND;
          3'b110:  alu_op_o = ALU_OR;
          default: begin
            illegal_o   = 1'b1;
            reg_write_o = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        use_imm_o   = 1'b1;
        reg_write_o = 1'b1;
        mem_read_o  = 1'b1;
      end
      OP_STORE: begin
        use_imm_o   = 1'b1;
        uses_rs2_o  = 1'b1;
        mem_write_o = 1'b1;
      end
      OP_BRANCH: begin
        alu_op_o   = ALU_SUB;
        uses_rs2_o = 1'b1;
        branch_o   = 1'b1;
      end
      OP_LUI: begin
        alu_op_o    = ALU_PASS;
        use_imm_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: registers decoded fields, applies
// MEM/WB forwarding to the operands and inserts bubbles on load-use hazards.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [6:0]           id_opcode,
  input  logic [2:0]           id_funct3,
  input  logic                 id_funct7_5,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic [RF_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic                 mem_reg_write,
  input  logic [RF_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_result,
  input  logic                 wb_reg_write,
  input  logic [RF_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_result,
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic [3:0]           ex_alu_op,
  output logic [XLEN-1:0]      ex_in1,
  output logic [XLEN-1:0]      ex_in2,
  output logic [XLEN-1:0]      ex_store_data,
  output logic [RF_ADDR_W-1:0] ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_branch,
  output logic [2:0]           ex_funct3,
  output logic                 ex_illegal
);

  alu_op_t dec_alu_op;
  logic    dec_reg_write, dec_mem_read, dec_mem_write, dec_branch;
  logic    dec_illegal, dec_use_imm, dec_uses_rs2;

  alu_ctrl_dec u_dec (
    .opcode_i    (id_opcode),
    .funct3_i    (id_funct3),
    .funct7_5_i  (id_funct7_5),
    .alu_op_o    (dec_alu_op),
    .reg_write_o (dec_reg_write),
    .mem_read_o  (dec_mem_read),
    .mem_write_o (dec_mem_write),
    .branch_o    (dec_branch),
    .illegal_o   (dec_illegal),
    .use_imm_o   (dec_use_imm),
    .uses_rs2_o  (dec_uses_rs2)
  );

  ex_ctrl_t             ctrl_d, ctrl_q, id_ctrl;
  alu_op_t              alu_op_d, alu_op_q;
  logic [2:0]           funct3_d, funct3_q;
  logic [RF_ADDR_W-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [XLEN-1:0]      rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q;
  logic [XLEN-1:0]      imm_d, imm_q;
  logic [XLEN-1:0]      fwd_rs1, fwd_rs2;

  assign id_ctrl = '{valid:     id_valid,
                     reg_write: dec_reg_write,
                     mem_read:  dec_mem_read,
                     mem_write: dec_mem_write,
                     branch:    dec_branch,
                     illegal:   dec_illegal,
                     use_imm:   dec_use_imm};

  // x0 is never a real producer, so a load targeting it cannot cause a stall.
  assign hazard_stall = ctrl_q.valid & ctrl_q.mem_read & (rd_q != '0) & id_valid &
                        ((rd_q == id_rs1) | (dec_uses_rs2 & (rd_q == id_rs2)));

  always_comb begin
    ctrl_d     = ctrl_q;
    alu_op_d   = alu_op_q;
    funct3_d   = funct3_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    if (flush || (!stall && hazard_stall)) begin
      ctrl_d   = '0;
      alu_op_d = ALU_AND;
      rd_d     = '0;
    end else if (!stall) begin
      ctrl_d     = id_ctrl;
      alu_op_d   = dec_alu_op;
      funct3_d   = id_funct3;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      alu_op_q   <= ALU_AND;
      funct3_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_op_q   <= alu_op_d;
      funct3_q   <= funct3_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    if (mem_reg_write && (mem_rd == rs1_q) && (rs1_q != '0))
      fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd == rs1_q) && (rs1_q != '0))
      fwd_rs1 = wb_result;
    else
      fwd_rs1 = rs1_data_q;

    if (mem_reg_write && (mem_rd == rs2_q) && (rs2_q != '0))
      fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd == rs2_q) && (rs2_q != '0))
      fwd_rs2 = wb_result;
    else
      fwd_rs2 = rs2_data_q;
  end

  assign ex_in1        = fwd_rs1;
  assign ex_in2        = ctrl_q.use_imm ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_valid      = ctrl_q.valid;
  assign ex_alu_op     = alu_op_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_funct3     = funct3_q;
  assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by a
// randomized run against a behavioural model of the EX register contents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        hazard_stall, ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_in1, ex_in2, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [2:0]  ex_funct3;

  int nChecks = 0;
  int nPass   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7_5(id_funct7_5), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // What EX should hold; bubble marks contents whose data fields are don't-care.
  typedef struct {
    logic        valid, bubble, rw, mr, mw, br, ill, useImm;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] d1, d2, imm;
  } exModel_t;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, LUI_OP = 7'b0110111;

  function automatic void refDecode(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                    output logic [3:0] op, output logic rw, output logic mr,
                                    output logic mw, output logic br, output logic ill,
                                    output logic useImm, output logic useRs2);
    op = 4'b0010; rw = 0; mr = 0; mw = 0; br = 0; ill = 0;
    useImm = (opc == I_OP) || (opc == LD_OP) || (opc == ST_OP) || (opc == LUI_OP);
    useRs2 = (opc == R_OP) || (opc == ST_OP) || (opc == BR_OP);
    if (opc == R_OP || opc == I_OP) begin
      if (f3 == 3'b000)      op = (opc == R_OP && f7) ? 4'b0110 : 4'b0010;
      else if (f3 == 3'b001) op = 4'b0011;
      else if (f3 == 3'b111) op = 4'b0000;
      else if (f3 == 3'b110) op = 4'b0001;
      else                   ill = 1;
      rw = !ill;
    end else if (opc == LD_OP) begin
      rw = 1; mr = 1;
    end else if (opc == ST_OP) begin
      mw = 1;
    end else if (opc == BR_OP) begin
      op = 4'b0110; br = 1;
    end else if (opc == LUI_OP) begin
      op = 4'b1000; rw = 1;
    end else begin
      ill = 1;
    end
  endfunction

  function automatic logic [31:0] refFwd(input logic [4:0] rs, input logic [31:0] regVal);
    if (rs == 0) return regVal;
    if (mem_reg_write && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd == rs) return wb_result;
    return regVal;
  endfunction

  task automatic driveIdle();
    stall = 0; flush = 0; id_valid = 0; id_opcode = 0; id_funct3 = 0; id_funct7_5 = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic driveId(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    id_valid = 1; id_opcode = opc; id_funct3 = f3; id_funct7_5 = f7;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic test_reset();
    rst = 1; driveIdle();
    #12;
    nChecks++; if (ex_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", ex_valid); else nPass++;
    nChecks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} !== 5'b0)
      $display("[TB] FAIL reset_ctrl: got %b want 00000",
               {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal});
    else nPass++;
    nChecks++; if (ex_alu_op !== 4'b0000) $display("[TB] FAIL reset_aluop: got %b want 0000", ex_alu_op); else nPass++;
    nChecks++; if (hazard_stall !== 1'b0) $display("[TB] FAIL reset_hazard: got %b want 0", hazard_stall); else nPass++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_rsub();
    @(negedge clk); driveId(R_OP, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0);
    @(posedge clk); #1;
    nChecks++; if (ex_alu_op !== 4'b0110) $display("[TB] FAIL rsub_aluop: got %b want 0110", ex_alu_op); else nPass++;
    nChecks++; if (ex_in1 !== 32'd10) $display("[TB] FAIL rsub_in1: got %0d want 10", ex_in1); else nPass++;
    nChecks++; if (ex_in2 !== 32'd3) $display("[TB] FAIL rsub_in2: got %0d want 3", ex_in2); else nPass++;
    nChecks++; if ({ex_valid, ex_reg_write} !== 2'b11) $display("[TB] FAIL rsub_valid_rw: got %b want 11", {ex_valid, ex_reg_write}); else nPass++;
    @(negedge clk); driveIdle();
  endtask

  task automatic test_forwarding();
    @(negedge clk); driveId(R_OP, 3'b000, 1'b0, 5'd5, 5'd5, 5'd7, 32'h11, 32'h22, 32'd0);
    @(posedge clk); #1;
    stall = 1;
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 5; wb_result = 32'hBB;
    #1;
    nChecks++; if (ex_in1 !== 32'hAA) $display("[TB] FAIL fwd_mem_in1: got %h want aa", ex_in1); else nPass++;
    nChecks++; if (ex_store_data !== 32'hAA) $display("[TB] FAIL fwd_mem_store: got %h want aa", ex_store_data); else nPass++;
    mem_reg_write = 0; #1;
    nChecks++; if (ex_in1 !== 32'hBB) $display("[TB] FAIL fwd_wb_in1: got %h want bb", ex_in1); else nPass++;
    nChecks++; if (ex_in2 !== 32'hBB) $display("[TB] FAIL fwd_wb_in2: got %h want bb", ex_in2); else nPass++;
    wb_reg_write = 0; #1;
    nChecks++; if (ex_in1 !== 32'h11) $display("[TB] FAIL fwd_none_in1: got %h want 11", ex_in1); else nPass++;
    @(negedge clk); stall = 0;
    driveId(R_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44, 32'd0);
    mem_reg_write = 1; mem_rd = 0; wb_reg_write = 1; wb_rd = 0;
    @(posedge clk); #1;
    nChecks++; if (ex_in1 !== 32'h33) $display("[TB] FAIL fwd_x0_in1: got %h want 33", ex_in1); else nPass++;
    nChecks++; if (ex_in2 !== 32'h44) $display("[TB] FAIL fwd_x0_in2: got %h want 44", ex_in2); else nPass++;
    @(negedge clk); driveIdle();
  endtask

  task automatic test_load_use();
    @(negedge clk); driveId(LD_OP, 3'b010, 1'b0, 5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8);
    @(posedge clk); #1;
    nChecks++; if ({ex_mem_read, ex_in2} !== {1'b1, 32'd8}) $display("[TB] FAIL lu_load: got mr=%b in2=%h want mr=1 in2=8", ex_mem_read, ex_in2); else nPass++;
    @(negedge clk); driveId(R_OP, 3'b000, 1'b0, 5'd4, 5'd6, 5'd5, 32'h1, 32'h2, 32'd0);
    #1;
    nChecks++; if (hazard_stall !== 1'b1) $display("[TB] FAIL lu_hazard: got %b want 1", hazard_stall); else nPass++;
    @(posedge clk); #1;
    nChecks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} !== 6'b0)
      $display("[TB] FAIL lu_bubble: got %b want 000000",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal});
    else nPass++;
    nChecks++; if (hazard_stall !== 1'b0) $display("[TB] FAIL lu_hazard_clear: got %b want 0", hazard_stall); else nPass++;
    @(posedge clk); #1;
    nChecks++; if ({ex_valid, ex_rd, ex_alu_op} !== {1'b1, 5'd5, 4'b0010})
      $display("[TB] FAIL lu_add_enters: got v=%b rd=%0d op=%b want v=1 rd=5 op=0010", ex_valid, ex_rd, ex_alu_op);
    else nPass++;
    @(negedge clk); driveId(LD_OP, 3'b010, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 32'd0, 32'd4);
    @(posedge clk); #1;
    @(negedge clk); driveId(R_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'd0);
    #1;
    nChecks++; if (hazard_stall !== 1'b0) $display("[TB] FAIL lu_x0_hazard: got %b want 0", hazard_stall); else nPass++;
    @(negedge clk); driveIdle();
  endtask

  task automatic test_flush();
    @(negedge clk); driveId(LD_OP, 3'b010, 1'b0, 5'd1, 5'd0, 5'd4, 32'h0, 32'd0, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); driveId(R_OP, 3'b000, 1'b0, 5'd4, 5'd6, 5'd5, 32'h1, 32'h2, 32'd0);
    stall = 1; flush = 1; #1;
    nChecks++; if (hazard_stall !== 1'b1) $display("[TB] FAIL flush_hazard_seen: got %b want 1", hazard_stall); else nPass++;
    @(posedge clk); #1;
    nChecks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} !== 6'b0)
      $display("[TB] FAIL flush_bubble: got %b want 000000",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal});
    else nPass++;
    @(negedge clk); driveIdle();
  endtask

  task automatic test_lui_illegal();
    @(negedge clk); driveId(LUI_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h12345000);
    @(posedge clk); #1;
    nChecks++; if (ex_alu_op !== 4'b1000) $display("[TB] FAIL lui_aluop: got %b want 1000", ex_alu_op); else nPass++;
    nChecks++; if (ex_in2 !== 32'h12345000) $display("[TB] FAIL lui_in2: got %h want 12345000", ex_in2); else nPass++;
    nChecks++; if (ex_reg_write !== 1'b1) $display("[TB] FAIL lui_rw: got %b want 1", ex_reg_write); else nPass++;
    @(negedge clk); driveId(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0);
    @(posedge clk); #1;
    nChecks++; if ({ex_illegal, ex_reg_write, ex_alu_op} !== {1'b1, 1'b0, 4'b0010})
      $display("[TB] FAIL illegal_op: got ill=%b rw=%b op=%b want ill=1 rw=0 op=0010", ex_illegal, ex_reg_write, ex_alu_op);
    else nPass++;
    @(negedge clk); driveIdle();
  endtask

  task automatic test_async_reset();
    @(negedge clk); driveId(R_OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 32'd0);
    @(posedge clk); #1;
    stall = 1;
    nChecks++; if (ex_valid !== 1'b1) $display("[TB] FAIL areset_pre_valid: got %b want 1", ex_valid); else nPass++;
    #2 rst = 1;
    #1;
    nChecks++; if ({ex_valid, ex_reg_write, ex_alu_op} !== 6'b0)
      $display("[TB] FAIL areset_clear: got v=%b rw=%b op=%b want all 0", ex_valid, ex_reg_write, ex_alu_op);
    else nPass++;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    nChecks++; if (ex_valid !== 1'b0) $display("[TB] FAIL areset_after_release: got %b want 0", ex_valid); else nPass++;
    @(negedge clk); driveIdle();
  endtask

  task automatic test_random();
    exModel_t m;
    logic [3:0] op;
    logic rw, mr, mw, br, ill, useImm, useRs2, expHaz;
    logic [31:0] expIn1, expFwd2, expIn2;
    @(negedge clk); driveIdle(); rst = 1; #2 rst = 0;
    m = '{valid: 0, bubble: 1, rw: 0, mr: 0, mw: 0, br: 0, ill: 0, useImm: 0,
          op: 0, rd: 0, rs1: 0, rs2: 0, f3: 0, d1: 0, d2: 0, imm: 0};
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0: id_opcode = R_OP;
        1: id_opcode = I_OP;
        2: id_opcode = LD_OP;
        3: id_opcode = ST_OP;
        4: id_opcode = BR_OP;
        5: id_opcode = LUI_OP;
        default: id_opcode = 7'($urandom);
      endcase
      id_funct3 = 3'($urandom_range(0, 7)); id_funct7_5 = 1'($urandom);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_valid = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 9) == 0); flush = ($urandom_range(0, 11) == 0);
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      #1;
      refDecode(id_opcode, id_funct3, id_funct7_5, op, rw, mr, mw, br, ill, useImm, useRs2);
      expHaz = m.valid && m.mr && m.rd != 0 && id_valid &&
               (m.rd == id_rs1 || (useRs2 && m.rd == id_rs2));
      nChecks++; if (hazard_stall !== expHaz) $display("[TB] FAIL rnd_hazard[%0d]: got %b want %b", i, hazard_stall, expHaz); else nPass++;
      if (!m.bubble) begin
        expIn1 = refFwd(m.rs1, m.d1);
        expFwd2 = refFwd(m.rs2, m.d2);
        expIn2 = m.useImm ? m.imm : expFwd2;
        nChecks++; if ({ex_in1, ex_in2, ex_store_data} !== {expIn1, expIn2, expFwd2})
          $display("[TB] FAIL rnd_operands[%0d]: got %h %h %h want %h %h %h", i,
                   ex_in1, ex_in2, ex_store_data, expIn1, expIn2, expFwd2);
        else nPass++;
      end
      if (flush || (!stall && expHaz)) begin
        m.valid = 0; m.bubble = 1; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0; m.ill = 0;
      end else if (!stall) begin
        m = '{valid: id_valid, bubble: 0, rw: rw, mr: mr, mw: mw, br: br, ill: ill, useImm: useImm,
              op: op, rd: id_rd, rs1: id_rs1, rs2: id_rs2, f3: id_funct3,
              d1: id_rs1_data, d2: id_rs2_data, imm: id_imm};
      end
      @(posedge clk); #1;
      nChecks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} !==
                     {m.valid, m.rw, m.mr, m.mw, m.br, m.ill})
        $display("[TB] FAIL rnd_ctrl[%0d]: got %b want %b", i,
                 {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal},
                 {m.valid, m.rw, m.mr, m.mw, m.br, m.ill});
      else nPass++;
      if (!m.bubble) begin
        nChecks++; if ({ex_alu_op, ex_rd, ex_funct3} !== {m.op, m.rd, m.f3})
          $display("[TB] FAIL rnd_fields[%0d]: got op=%b rd=%0d f3=%b want op=%b rd=%0d f3=%b", i,
                   ex_alu_op, ex_rd, ex_funct3, m.op, m.rd, m.f3);
        else nPass++;
      end
    end
    @(negedge clk); driveIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_rsub();
    test_forwarding();
    test_load_use();
    test_flush();
    test_lui_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU in the execute stage.
- Registers decoded instruction fields and generates the 4-bit ALU op code.
- Applies MEM/WB operand forwarding and drives in1/in2/alu_op into the ALU.
- Detects load-use hazards and inserts a bubble.

Parameters:
- XLEN, 32, datapath width.
- RF_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  downstream stall; hold all EX state.
- flush  in  1  branch/jump flush; load a bubble.
- id_valid  in  1  ID holds a valid instruction.
- id_opcode  in  7  instruction[6:0].
- id_funct3  in  3  instruction[14:12].
- id_funct7_5  in  1  instruction[30].
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  sign-extended immediate.
- mem_reg_write, mem_rd, mem_result  in  1/5/32  MEM-stage writeback info.
- wb_reg_write, wb_rd, wb_result  in  1/5/32  WB-stage writeback info.
- hazard_stall  out  1  load-use stall request to IF/ID (combinational).
- ex_valid  out  1  EX holds a valid instruction.
- ex_alu_op  out  4  to ALU alu_op.
- ex_in1, ex_in2  out  32 each  to ALU in1/in2 (combinational mux of registered state).
- ex_store_data  out  32  forwarded rs2 value.
- ex_rd  out  5  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  registered control.
- ex_funct3  out  3  registered funct3, for branch/memory width.
- ex_illegal  out  1  registered unsupported-opcode flag.

Behaviour:
- Reset: every registered field is 0, so ex_valid=0, all controls 0 and ex_alu_op=0000. Reset mid-stall also clears, regardless of stall/flush.
- Register update priority on a clock edge, first match wins:
  - flush: load a bubble.
  - stall: hold.
  - hazard_stall: load a bubble.
  - otherwise: load ID fields, with valid=id_valid.
- Bubble: valid, reg_write, mem_read, mem_write, branch and illegal all 0; data fields don't-care.
- Latency: one cycle, ID to EX registers. Forwarding and in1/in2 selection are combinational within EX.
- alu_op decode is done in ID and registered:
  - Op code values: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0110, PASS 1000.
  - 0110011 (R-type), by funct3: 000 gives SUB if funct7_5 else ADD; 001 SLL; 111 AND; 110 OR.
  - 0010011 (I-type), by funct3: 000 ADD; 001 SLL; 111 AND; 110 OR.
  - 0000011 (load) and 0100011 (store): ADD.
  - 1100011 (branch): SUB and branch=1. The ALU's less/zero flags are consumed downstream.
  - 0110111 (LUI): PASS.
  - Any other opcode/funct3: ADD, illegal=1, reg_write=0.
- Controls:
  - reg_write set for R/I/load/LUI.
  - mem_read set for load; mem_write set for store.
- Forwarding, applied independently to rs1 and rs2:
  - If mem_reg_write and mem_rd==rs and rs!=0, use mem_result.
  - Else if wb_reg_write and wb_rd==rs and rs!=0, use wb_result.
  - Else use the registered data.
  - MEM has priority over WB.
- Operand select:
  - ex_in1 is fwd_rs1.
  - ex_in2 is the registered imm for I/load/store/LUI, else fwd_rs2.
  - ex_store_data is always fwd_rs2.
- Load-use hazard: hazard_stall = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (uses_rs2 & ex_rd==id_rs2)) & id_valid.
  - uses_rs2 holds for R, store and branch.
- flush takes priority over a concurrent hazard; hazard_stall may still assert but the result is a bubble.
- Register x0: a writeback to rd=0 never forwards and never triggers a hazard.

Decomposition:
- Package pipe_pkg holds:
  - alu_op_t: 4-bit enum with the six codes above.
  - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI.
  - ex_ctrl_t: packed struct of the registered control bits.
- One sub-module, alu_ctrl_dec: combinational decode of opcode/funct3/funct7_5 into alu_op_t plus controls and illegal.

Test Plan:
- R-type sub, x3=x1-x2: funct7_5=1, rs1_data=10, rs2_data=3, no forwarding → next cycle ex_alu_op=0110, ex_in1=10, ex_in2=3, ex_reg_write=1.
- MEM over WB forwarding: EX rs1=5; mem_rd=5 with mem_result=0xAA; wb_rd=5 with wb_result=0xBB → ex_in1=0xAA. Drop mem_reg_write → ex_in1=0xBB. Set rs=0 → the registered value is used.
- Load-use: EX is lw x4 (ex_mem_read=1); ID is add x5,x4,x6 → hazard_stall=1 for one cycle; next cycle ex_valid=0 with all controls 0; the add enters the cycle after.
- Flush concurrent with stall and hazard: flush=1, stall=1 → next edge ex_valid=0 and all controls 0.
- LUI with imm=0x12345000 → ex_alu_op=1000, ex_in2=0x12345000. Opcode 1111111 → ex_illegal=1, ex_reg_write=0, ex_alu_op=0010.
- Async reset asserted mid-cycle with a valid instruction held under stall → outputs clear immediately without a clock edge; ex_valid=0 after release.
